// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: state encoding shared by the serial arithmetic controllers
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// fulladder: single-bit full adder cell, in_i = {carry, b_bit, a_bit}
module fulladder (
    input  logic [2:0] in_i,
    output logic [1:0] out_o
);

    // Sum is the parity of the three inputs; carry is their majority
    always_comb begin
        out_o[0] = ^in_i;
        out_o[1] = (in_i[0] & in_i[1]) | (in_i[2] & (in_i[0] ^ in_i[1]));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder built around one full-adder cell
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, sum_q;
    logic             c_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       fa_out;
    logic             accept, last;

    // Ripple-toggle increment keeps the only adder in this block the serial cell
    function automatic logic [CW-1:0] incr(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        c = 1'b1;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

    fulladder u_fa (
        .in_i ({c_q, b_sr_q[0], a_sr_q[0]}),
        .out_o(fa_out)
    );

    assign accept = start && (state_q != S_ADD);
    assign last   = (state_q == S_ADD) && (cnt_q == CW'(WIDTH - 1));
    assign busy   = (state_q == S_ADD);
    assign done   = (state_q == S_DONE);
    assign sum    = sum_q;
    assign cout   = cout_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: ADD runs WIDTH cycles, DONE lasts one cycle and may reload
    always_comb begin
        state_d = state_q;
        state_d = (state_q == S_ADD) ? (last ? S_DONE : S_ADD) : (start ? S_ADD : S_IDLE);
    end

    // Datapath: operand load, serial shift, carry feedback and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q <= '0;
            b_sr_q <= '0;
            s_sr_q <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr_q <= a;
            b_sr_q <= b;
            c_q    <= cin;
            cnt_q  <= '0;
        end else if (state_q == S_ADD) begin
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            s_sr_q <= {fa_out[0], s_sr_q[WIDTH-1:1]};
            c_q    <= fa_out[1];
            cnt_q  <= incr(cnt_q);
            if (last) begin
                sum_q  <= {fa_out[0], s_sr_q[WIDTH-1:1]};
                cout_q <= fa_out[1];
            end
        end
    end

endmodule
